// File: rtl/mod_cascade_counter_pkg.sv
// Shared definitions for the cascaded modulo counter: digit width helper, direction
// constants and the per-digit terminal value.
package mod_cascade_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits needed to hold 0..modulus-1; at least one bit.
  function automatic int unsigned calc_w(input int unsigned modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

  function automatic int unsigned term_val(input logic up, input int unsigned modulus);
    return (up == DIR_UP) ? (modulus - 1) : 0;
  endfunction

endpackage

// File: rtl/mod_cascade_counter_digit.sv
// One modulo-MODULUS digit: synchronous reset, clamped parallel load, up/down step.
module mod_digit
  import mod_cascade_counter_pkg::*;
#(
  parameter int unsigned MODULUS = 12,
  parameter int unsigned W       = calc_w(MODULUS)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         step,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         is_term
);

  localparam logic [W-1:0] MaxVal = W'(MODULUS - 1);

  logic [W-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (step) begin
      if (up == DIR_UP) begin
        value_d = (value_q == MaxVal) ? '0 : value_q + W'(1);
      end else begin
        value_d = (value_q == '0) ? MaxVal : value_q - W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign is_term = (value_q == W'(term_val(up, MODULUS)));

endmodule

// File: rtl/mod_cascade_counter.sv
// Multi-digit cascaded modulo counter with up/down, enable, load and carry out.
// Optional macro COUNTER_SATURATE_EN makes the counter hold at its terminal state.
module mod_cascade_counter
  import mod_cascade_counter_pkg::*;
#(
  parameter int unsigned MODULUS = 12,
  parameter int unsigned DIGITS  = 2,
  localparam int unsigned W      = calc_w(MODULUS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [DIGITS*W-1:0] load_val,
  output logic [DIGITS*W-1:0] out,
  output logic              tc,
  output logic              overflow
);

  logic [DIGITS-1:0] is_term;
  logic [DIGITS-1:0] step;
  logic [DIGITS:0]   carry;
  logic              count_ok;

  assign tc       = &is_term;
  assign overflow = tc & en & ~load;

`ifdef COUNTER_SATURATE_EN
  // Terminal state blocks the step so the counter parks instead of wrapping.
  assign count_ok = en & ~load & ~tc;
`else
  assign count_ok = en & ~load;
`endif

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign carry[i+1] = carry[i] & is_term[i];
    assign step[i]    = count_ok & carry[i];

    mod_digit #(
      .MODULUS (MODULUS),
      .W       (W)
    ) u_digit (
      .clock    (clock),
      .reset    (reset),
      .step     (step[i]),
      .up       (up),
      .load     (load),
      .load_val (load_val[i*W +: W]),
      .value    (out[i*W +: W]),
      .is_term  (is_term[i])
    );
  end

endmodule

// File: tb/tb_mod_cascade_counter.sv
// Directed self-checking bench for mod_cascade_counter (12x2 and 16x1 instances).
module tb_mod_cascade_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, en, up, load;
  logic [7:0] load_val;
  logic [7:0] out;
  logic       tc, overflow;

  logic       reset16, en16, up16, load16;
  logic [3:0] load_val16;
  logic [3:0] out16;
  logic       tc16, overflow16;

  int asserts = 0;
  int fails   = 0;

  always #5 clock = ~clock;

  mod_cascade_counter #(.MODULUS(12), .DIGITS(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .tc       (tc),
    .overflow (overflow)
  );

  mod_cascade_counter #(.MODULUS(16), .DIGITS(1)) dut16 (
    .clock    (clock),
    .reset    (reset16),
    .en       (en16),
    .up       (up16),
    .load     (load16),
    .load_val (load_val16),
    .out      (out16),
    .tc       (tc16),
    .overflow (overflow16)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_value(input logic [7:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    tick();
    load = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; load_val = 8'h00;
    tick();
    reset = 1'b0; en = 1'b0;
    #1;
    asserts++;
    if (out !== 8'h00) begin
      fails++; $display("FAIL reset_out: got %h expected 00", out);
    end
    asserts++;
    if (tc !== 1'b1) begin
      fails++; $display("FAIL reset_tc_down: got %b expected 1", tc);
    end
    asserts++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
  endtask

  task automatic test_count_up();
    logic [7:0] exp;
    up = 1'b1; en = 1'b1;
    #1;
    for (int k = 0; k < 144; k++) begin
      exp = {4'(k / 12), 4'(k % 12)};
      asserts++;
      if (out !== exp) begin
        fails++; $display("FAIL count_up_out k=%0d: got %h expected %h", k, out, exp);
      end
      asserts++;
      if (overflow !== (k == 143)) begin
        fails++; $display("FAIL count_up_ovf k=%0d: got %b expected %b", k, overflow, k == 143);
      end
      tick();
    end
    exp = Sat ? 8'hBB : 8'h00;
    asserts++;
    if (out !== exp) begin
      fails++; $display("FAIL count_up_wrap: got %h expected %h", out, exp);
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    load = 1'b1; load_val = {4'd3, 4'd11}; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b0;
    #1;
    asserts++;
    if (out !== 8'h3B) begin
      fails++; $display("FAIL load_value: got %h expected 3b", out);
    end
    tick();
    asserts++;
    if (out !== 8'h40) begin
      fails++; $display("FAIL load_then_step: got %h expected 40", out);
    end
    load = 1'b1; load_val = {4'd2, 4'd15};
    tick();
    load = 1'b0; en = 1'b0;
    #1;
    asserts++;
    if (out !== 8'h2B) begin
      fails++; $display("FAIL load_clamp: got %h expected 2b", out);
    end
    // At terminal state a pending load must suppress the carry out.
    load_value(8'hBB);
    load = 1'b1; en = 1'b1; load_val = 8'h12;
    #1;
    asserts++;
    if (tc !== 1'b1 || overflow !== 1'b0) begin
      fails++; $display("FAIL load_blocks_ovf: got tc=%b ovf=%b expected tc=1 ovf=0", tc, overflow);
    end
    tick();
    load = 1'b0; en = 1'b0;
    #1;
    asserts++;
    if (out !== 8'h12) begin
      fails++; $display("FAIL load_over_en: got %h expected 12", out);
    end
  endtask

  task automatic test_down();
    logic [7:0] exp;
    load_value(8'h00);
    up = 1'b1;
    #1;
    asserts++;
    if (tc !== 1'b0) begin
      fails++; $display("FAIL dir_tc_up: got %b expected 0", tc);
    end
    up = 1'b0; en = 1'b1;
    #1;
    asserts++;
    if (tc !== 1'b1 || overflow !== 1'b1) begin
      fails++; $display("FAIL down_tc_ovf: got tc=%b ovf=%b expected 1 1", tc, overflow);
    end
    tick();
    exp = Sat ? 8'h00 : 8'hBB;
    asserts++;
    if (out !== exp) begin
      fails++; $display("FAIL down_wrap: got %h expected %h", out, exp);
    end
    if (!Sat) begin
      tick();
      asserts++;
      if (out !== 8'hBA) begin
        fails++; $display("FAIL down_step: got %h expected ba", out);
      end
    end
    load_value(8'h50);
    up = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    asserts++;
    if (out !== 8'h4B) begin
      fails++; $display("FAIL down_borrow: got %h expected 4b", out);
    end
  endtask

  task automatic test_enable();
    load_value(8'h57);
    up = 1'b1; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      asserts++;
      if (out !== 8'h57 || overflow !== 1'b0) begin
        fails++; $display("FAIL enable_hold k=%0d: got out=%h ovf=%b expected 57 0", k, out, overflow);
      end
    end
    up = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    asserts++;
    if (out !== 8'h56) begin
      fails++; $display("FAIL enable_dir_flip: got %h expected 56", out);
    end
  endtask

  task automatic test_reset_priority();
    load_value(8'h99);
    reset = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; load_val = 8'h34;
    tick();
    reset = 1'b0; load = 1'b0; en = 1'b0;
    #1;
    asserts++;
    if (out !== 8'h00) begin
      fails++; $display("FAIL reset_priority: got %h expected 00", out);
    end
  endtask

  task automatic test_mod16();
    logic [3:0] exp;
    reset16 = 1'b1; en16 = 1'b0; up16 = 1'b1; load16 = 1'b0; load_val16 = 4'h0;
    tick();
    reset16 = 1'b0; en16 = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) begin
      asserts++;
      if (out16 !== 4'(k) || overflow16 !== (k == 15)) begin
        fails++;
        $display("FAIL mod16_walk k=%0d: got out=%h ovf=%b expected %h %b",
                 k, out16, overflow16, 4'(k), k == 15);
      end
      tick();
    end
    exp = Sat ? 4'hF : 4'h0;
    asserts++;
    if (out16 !== exp) begin
      fails++; $display("FAIL mod16_wrap: got %h expected %h", out16, exp);
    end
    en16 = 1'b0;
  endtask

  task automatic test_terminal();
    load_value(8'hBB);
    up = 1'b1; en = 1'b1;
    if (Sat) begin
      for (int k = 0; k < 5; k++) begin
        asserts++;
        if (overflow !== 1'b1) begin
          fails++; $display("FAIL sat_ovf k=%0d: got %b expected 1", k, overflow);
        end
        tick();
        asserts++;
        if (out !== 8'hBB) begin
          fails++; $display("FAIL sat_hold k=%0d: got %h expected bb", k, out);
        end
      end
      up = 1'b0;
      tick();
      asserts++;
      if (out !== 8'hBA) begin
        fails++; $display("FAIL sat_leave: got %h expected ba", out);
      end
    end else begin
      tick();
      asserts++;
      if (out !== 8'h00) begin
        fails++; $display("FAIL wrap_up: got %h expected 00", out);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    reset16 = 1'b1; en16 = 1'b0; up16 = 1'b1; load16 = 1'b0; load_val16 = 4'h0;
    test_reset();
    test_count_up();
    test_load();
    test_down();
    test_enable();
    test_reset_priority();
    test_mod16();
    test_terminal();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
